smart_lock_ctrl: RTL and testbench

Front-end controller for the smart lock. It turns raw keypad activity (one-hot digit keys, enter, delete, lock) into 4-digit code transactions against the code-store. It sequences save, delete and unlock-lookup requests over a req/ack handshake, and owns the door-lock state, error signalling, entry timeout and brute-force lockout.

---
 rtl/smart_lock_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_smart_lock_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smart_lock_ctrl.sv
// ---------------------------------------------------------------------------
// smart_lock_ctrl
//
// Keypad front end for the smart lock. It collects 4-digit BCD codes from
// one-hot digit keys and turns them into lookup / save / delete transactions
// on a req/ack handshake towards the code store. It also owns the door-lock
// state, the error pulse, the partial-entry timeout and the brute-force
// lockout.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   buttons_i      digit keys 0-9 (level, one-hot when pressed)
//   enter_i        save request key (level)
//   delete_i       delete request key (level)
//   lock_i         lock key (level)
//   st_req_o       code-store request, held until st_ack_i
//   st_cmd_o       00 lookup, 01 save, 10 delete
//   st_code_o      buffered BCD digits, first-entered digit in [15:12]
//   st_ack_i       code-store completion strobe (single cycle)
//   st_ok_i        code-store result, valid with st_ack_i
//   door_locked_o  1 = door locked
//   error_o        error indication, ERR_CYCLES cycles per event
//   lockout_o      keypad disabled after MAX_FAILS failed lookups
//   digit_cnt_o    number of buffered digits (0-4)
// ---------------------------------------------------------------------------
module smart_lock_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 5000,
    parameter int ERR_CYCLES     = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [9:0]  buttons_i,
    input  logic        enter_i,
    input  logic        delete_i,
    input  logic        lock_i,
    output logic        st_req_o,
    output logic [1:0]  st_cmd_o,
    output logic [15:0] st_code_o,
    input  logic        st_ack_i,
    input  logic        st_ok_i,
    output logic        door_locked_o,
    output logic        error_o,
    output logic        lockout_o,
    output logic [2:0]  digit_cnt_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam int EW = $clog2(ERR_CYCLES + 1);

    localparam logic [1:0] CMD_LOOKUP = 2'b00;
    localparam logic [1:0] CMD_SAVE   = 2'b01;
    localparam logic [1:0] CMD_DELETE = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_LOCKOUT} state_e;

    state_e      state_q;
    logic [9:0]  btn_q;
    logic        enter_q, delete_q, lock_q;
    logic        st_req_q;
    logic [1:0]  st_cmd_q;
    logic [15:0] code_q;
    logic [2:0]  digit_cnt_q;
    logic        door_locked_q;
    logic        lockout_q;
    logic [FW-1:0] fail_cnt_q;
    logic [EW-1:0] err_cnt_q;
    logic [LW-1:0] lock_cnt_q;
    logic [TW-1:0] tmo_cnt_q;

    // Rising edges: current sample against last cycle's registered keys.
    logic [9:0] btn_rise;
    logic       enter_rise, delete_rise, lock_rise, any_rise, multi_rise;
    logic [3:0] digit_val;

    assign btn_rise    = buttons_i & ~btn_q;
    assign enter_rise  = enter_i  & ~enter_q;
    assign delete_rise = delete_i & ~delete_q;
    assign lock_rise   = lock_i   & ~lock_q;
    assign any_rise    = (|btn_rise) | enter_rise | delete_rise | lock_rise;
    // More than one bit set <=> clearing the lowest set bit leaves something.
    assign multi_rise  = (btn_rise & (btn_rise - 10'd1)) != 10'd0;

    always_comb begin
        digit_val = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (btn_rise[i]) digit_val = 4'(i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            btn_q         <= '0;
            enter_q       <= 1'b0;
            delete_q      <= 1'b0;
            lock_q        <= 1'b0;
            st_req_q      <= 1'b0;
            st_cmd_q      <= CMD_LOOKUP;
            code_q        <= '0;
            digit_cnt_q   <= '0;
            door_locked_q <= 1'b0;
            lockout_q     <= 1'b0;
            fail_cnt_q    <= '0;
            err_cnt_q     <= '0;
            lock_cnt_q    <= '0;
            tmo_cnt_q     <= '0;
        end else begin
            btn_q    <= buttons_i;
            enter_q  <= enter_i;
            delete_q <= delete_i;
            lock_q   <= lock_i;

            // Error pulse counts down; any error event below reloads it.
            if (err_cnt_q != '0) err_cnt_q <= err_cnt_q - 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (lock_rise) begin
                        door_locked_q <= 1'b1;
                        code_q        <= '0;
                        digit_cnt_q   <= '0;
                    end else if (delete_rise || enter_rise) begin
                        if (door_locked_q || digit_cnt_q != 3'd4) begin
                            err_cnt_q   <= EW'(ERR_CYCLES);
                            code_q      <= '0;
                            digit_cnt_q <= '0;
                        end else begin
                            state_q  <= S_REQ;
                            st_cmd_q <= delete_rise ? CMD_DELETE : CMD_SAVE;
                        end
                    end else if (|btn_rise) begin
                        if (multi_rise) begin
                            err_cnt_q <= EW'(ERR_CYCLES);
                        end else if (digit_cnt_q != 3'd4) begin
                            code_q      <= {code_q[11:0], digit_val};
                            digit_cnt_q <= digit_cnt_q + 3'd1;
                            // Locked: the 4th digit launches the lookup.
                            if (door_locked_q && digit_cnt_q == 3'd3) begin
                                state_q  <= S_REQ;
                                st_cmd_q <= CMD_LOOKUP;
                            end
                        end
                    end

                    // Timeout only runs while something is buffered and
                    // no key edge arrives; it is exclusive with edge handling.
                    if (any_rise || digit_cnt_q == 3'd0) begin
                        tmo_cnt_q <= '0;
                    end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        tmo_cnt_q   <= '0;
                        code_q      <= '0;
                        digit_cnt_q <= '0;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end

                S_REQ: begin
                    tmo_cnt_q <= '0;
                    // st_req_q is raised one cycle after entering REQ, so an
                    // ack is only honoured once the request is visible.
                    if (st_req_q && st_ack_i) begin
                        st_req_q    <= 1'b0;
                        code_q      <= '0;
                        digit_cnt_q <= '0;
                        state_q     <= S_IDLE;
                        if (st_cmd_q == CMD_LOOKUP) begin
                            if (st_ok_i) begin
                                door_locked_q <= 1'b0;
                                fail_cnt_q    <= '0;
                            end else begin
                                err_cnt_q  <= EW'(ERR_CYCLES);
                                fail_cnt_q <= fail_cnt_q + 1'b1;
                                if ((fail_cnt_q + 1'b1) == FW'(MAX_FAILS)) begin
                                    state_q    <= S_LOCKOUT;
                                    lockout_q  <= 1'b1;
                                    lock_cnt_q <= LW'(LOCKOUT_CYCLES - 1);
                                end
                            end
                        end else if (!st_ok_i) begin
                            err_cnt_q <= EW'(ERR_CYCLES);
                        end
                    end else begin
                        st_req_q <= 1'b1;
                    end
                end

                S_LOCKOUT: begin
                    tmo_cnt_q <= '0;
                    if (lock_cnt_q == '0) begin
                        lockout_q  <= 1'b0;
                        fail_cnt_q <= '0;
                        state_q    <= S_IDLE;
                    end else begin
                        lock_cnt_q <= lock_cnt_q - 1'b1;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign st_req_o      = st_req_q;
    assign st_cmd_o      = st_cmd_q;
    assign st_code_o     = code_q;
    assign door_locked_o = door_locked_q;
    assign error_o       = (err_cnt_q != '0);
    assign lockout_o     = lockout_q;
    assign digit_cnt_o   = digit_cnt_q;

endmodule

// File: tb/tb_smart_lock_ctrl.sv
// ---------------------------------------------------------------------------
// tb_smart_lock_ctrl
//
// Directed walk through the lock's main scenarios followed by randomized
// keypad / code-store traffic. Expected outputs come from a behavioural model
// that keeps the entered digits in a queue and tracks the lock's pending
// request, error and lockout durations as plain counters.
// ---------------------------------------------------------------------------
module tb_smart_lock_ctrl;
    localparam int TMO   = 40;
    localparam int MAXF  = 3;
    localparam int LOCKC = 60;
    localparam int ERRC  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  buttons;
    logic        enter, del, lock, st_ack, st_ok;
    logic        st_req;
    logic [1:0]  st_cmd;
    logic [15:0] st_code;
    logic        door_locked, error, lockout;
    logic [2:0]  digit_cnt;

    always #5 clk = ~clk;

    smart_lock_ctrl #(
        .TIMEOUT_CYCLES(TMO),
        .MAX_FAILS     (MAXF),
        .LOCKOUT_CYCLES(LOCKC),
        .ERR_CYCLES    (ERRC)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .buttons_i    (buttons),
        .enter_i      (enter),
        .delete_i     (del),
        .lock_i       (lock),
        .st_req_o     (st_req),
        .st_cmd_o     (st_cmd),
        .st_code_o    (st_code),
        .st_ack_i     (st_ack),
        .st_ok_i      (st_ok),
        .door_locked_o(door_locked),
        .error_o      (error),
        .lockout_o    (lockout),
        .digit_cnt_o  (digit_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    int         m_digits[$];
    bit         m_locked;
    int         m_fails, m_err, m_lockout, m_idle, m_cmd;
    bit         m_pending, m_req_vis;
    logic [9:0] m_pb;
    logic       m_pe, m_pd, m_pl;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int m_code();
        int c = 0;
        foreach (m_digits[i]) c = c * 16 + m_digits[i];
        return c;
    endfunction

    task automatic model_reset();
        m_digits.delete();
        m_locked = 0; m_fails = 0; m_err = 0; m_lockout = 0; m_idle = 0;
        m_cmd = 0; m_pending = 0; m_req_vis = 0;
        m_pb = '0; m_pe = 0; m_pd = 0; m_pl = 0;
    endtask

    // One clock edge of the lock's behaviour, using the inputs now applied.
    task automatic model_step();
        logic [9:0] br;
        logic er, dr, lr;
        bit anye;
        br = buttons & ~m_pb;
        er = enter & ~m_pe;
        dr = del & ~m_pd;
        lr = lock & ~m_pl;
        m_pb = buttons; m_pe = enter; m_pd = del; m_pl = lock;
        anye = (br != 0) || er || dr || lr;
        if (m_err > 0) m_err--;

        if (m_lockout > 0) begin
            m_lockout--;
            if (m_lockout == 0) m_fails = 0;
            m_idle = 0;
        end else if (m_pending) begin
            m_idle = 0;
            if (m_req_vis && st_ack) begin
                m_pending = 0;
                m_req_vis = 0;
                m_digits.delete();
                if (m_cmd == 0) begin
                    if (st_ok) begin
                        m_locked = 0;
                        m_fails  = 0;
                    end else begin
                        m_err = ERRC;
                        if (m_fails < MAXF) m_fails++;
                        if (m_fails == MAXF) m_lockout = LOCKC;
                    end
                end else if (!st_ok) begin
                    m_err = ERRC;
                end
            end else begin
                m_req_vis = 1;
            end
        end else begin
            if (lr) begin
                m_locked = 1;
                m_digits.delete();
            end else if (dr || er) begin
                if (m_locked || m_digits.size() != 4) begin
                    m_err = ERRC;
                    m_digits.delete();
                end else begin
                    m_pending = 1;
                    m_cmd = dr ? 2 : 1;
                end
            end else if (br != 0) begin
                if ($countones(br) > 1) begin
                    m_err = ERRC;
                end else if (m_digits.size() < 4) begin
                    m_digits.push_back($clog2(br));
                    if (m_locked && m_digits.size() == 4) begin
                        m_pending = 1;
                        m_cmd = 0;
                    end
                end
            end
            if (anye || m_digits.size() == 0) begin
                m_idle = 0;
            end else begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_digits.delete();
                    m_idle = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        check_eq("st_req",  32'(st_req),      32'(m_req_vis));
        check_eq("dcnt",    32'(digit_cnt),   32'(m_digits.size()));
        check_eq("code",    32'(st_code),     32'(m_code()));
        check_eq("locked",  32'(door_locked), 32'(m_locked));
        check_eq("error",   32'(error),       32'(m_err > 0));
        check_eq("lockout", 32'(lockout),     32'(m_lockout > 0));
        if (m_req_vis) check_eq("st_cmd", 32'(st_cmd), 32'(m_cmd));
    endtask

    // Called at a negedge: apply inputs, clock once, compare at next negedge.
    task automatic tick(input logic [9:0] b, input logic en, input logic de,
                        input logic lk, input logic ack, input logic ok);
        buttons = b; enter = en; del = de; lock = lk; st_ack = ack; st_ok = ok;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic press(input int d);
        tick(10'd1 << d, 0, 0, 0, 0, 0);
        tick('0, 0, 0, 0, 0, 0);
    endtask

    task automatic press4(input int a, input int b, input int c, input int d);
        press(a); press(b); press(c); press(d);
    endtask

    initial begin
        logic [9:0] rb;
        logic       ren, rde, rlk;
        int         r;
        rst_n = 1'b0;
        buttons = '0; enter = 0; del = 0; lock = 0; st_ack = 0; st_ok = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        compare_all();
        check_eq("rst_cmd", 32'(st_cmd), 32'd0);
        rst_n = 1'b1;

        // Unlocked save of 1234
        press(1); check_eq("cnt1", 32'(digit_cnt), 32'd1);
        press(2); press(3);
        press(4); check_eq("cnt4", 32'(digit_cnt), 32'd4);
        tick('0, 1, 0, 0, 0, 0);
        check_eq("req_lat", 32'(st_req), 32'd0);
        tick('0, 0, 0, 0, 0, 0);
        check_eq("save_req", 32'(st_req), 32'd1);
        check_eq("save_cmd", 32'(st_cmd), 32'd1);
        check_eq("save_code", 32'(st_code), 32'h1234);
        tick('0, 0, 0, 0, 1, 1);
        check_eq("save_done", 32'(st_req), 32'd0);
        check_eq("save_err", 32'(error), 32'd0);

        // Lock, then successful lookup of 1234
        tick('0, 0, 0, 1, 0, 0); tick('0, 0, 0, 0, 0, 0);
        check_eq("locked", 32'(door_locked), 32'd1);
        press4(1, 2, 3, 4);
        check_eq("lk_cmd", 32'(st_cmd), 32'd0);
        check_eq("lk_code", 32'(st_code), 32'h1234);
        tick('0, 0, 0, 0, 1, 1);
        check_eq("unlocked", 32'(door_locked), 32'd0);

        // Three failed lookups -> lockout
        tick('0, 0, 0, 1, 0, 0); tick('0, 0, 0, 0, 0, 0);
        for (int k = 0; k < MAXF; k++) begin
            press4(1, 3, 5, 7);
            tick('0, 0, 0, 0, 1, 0);
            check_eq("fail_err", 32'(error), 32'd1);
        end
        check_eq("lockout_on", 32'(lockout), 32'd1);
        for (int k = 0; k < LOCKC - 4; k++)
            tick((k % 2) ? 10'd0 : (10'd1 << (k % 10)), 0, 0, 0, 0, 0);
        check_eq("lo_cnt", 32'(digit_cnt), 32'd0);
        check_eq("lo_hold", 32'(lockout), 32'd1);
        repeat (10) tick('0, 0, 0, 0, 0, 0);
        check_eq("lo_off", 32'(lockout), 32'd0);
        check_eq("lo_door", 32'(door_locked), 32'd1);

        // Unlock, then short entry + enter -> error
        press4(2, 4, 6, 8);
        tick('0, 0, 0, 0, 1, 1);
        press(5); press(6);
        tick('0, 1, 0, 0, 0, 0);
        check_eq("short_err", 32'(error), 32'd1);
        check_eq("short_cnt", 32'(digit_cnt), 32'd0);
        tick('0, 0, 0, 0, 0, 0);
        check_eq("short_req", 32'(st_req), 32'd0);

        // Timeout boundary, then multi-digit rejection
        press(9); press(0);
        repeat (TMO - 2) tick('0, 0, 0, 0, 0, 0);
        check_eq("tmo_before", 32'(digit_cnt), 32'd2);
        tick('0, 0, 0, 0, 0, 0);
        check_eq("tmo_after", 32'(digit_cnt), 32'd0);
        check_eq("tmo_err", 32'(error), 32'd0);
        press(7);
        tick(10'h003, 0, 0, 0, 0, 0);
        check_eq("multi_err", 32'(error), 32'd1);
        check_eq("multi_cnt", 32'(digit_cnt), 32'd1);
        tick('0, 0, 0, 0, 0, 0);

        // Reset in the middle of a lookup request
        tick('0, 0, 0, 1, 0, 0); tick('0, 0, 0, 0, 0, 0);
        press4(1, 2, 3, 4);
        check_eq("pre_rst_req", 32'(st_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_req", 32'(st_req), 32'd0);
        check_eq("arst_door", 32'(door_locked), 32'd0);
        check_eq("arst_cnt", 32'(digit_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick('0, 0, 0, 0, 1, 1);
        check_eq("late_ack", 32'(st_req), 32'd0);

        // Randomized traffic, with quiet windows so the timeout can fire
        for (int i = 0; i < 3000; i++) begin
            rb = '0; ren = 0; rde = 0; rlk = 0;
            r = $urandom_range(0, 99);
            if ((i % 300) < 240) begin
                if (r < 40)      rb = 10'd1 << $urandom_range(0, 9);
                else if (r < 43) rb = (10'd1 << $urandom_range(0, 9)) | (10'd1 << $urandom_range(0, 9));
                else if (r < 48) ren = 1;
                else if (r < 52) rde = 1;
                else if (r < 54) rlk = 1;
            end
            tick(rb, ren, rde, rlk, 1'($urandom_range(0, 99) < 30), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
